sliced_adder: RTL and testbench

Parametrised multi-cycle binary adder/subtractor, the clocked successor of the 4-bit full-adder chip block. Latched WIDTH-bit operands are processed in SLICE-bit slices, least significant first, with the carry held in a register between slices. The block exchanges a start/busy/done handshake with a front-end controller. It sits between the operand registers (switches or a counter) and the display/LED logic on the board.

---
 rtl/sliced_adder_pkg.sv | 16 +
 rtl/slice_add.sv | 37 +++
 rtl/sliced_adder.sv | 149 ++++++++++++++
 tb/tb_sliced_adder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sliced_adder_pkg.sv
// Shared definitions for the sliced adder: FSM state encoding and default geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sliced_adder_pkg;

    // Default operand width and bits processed per clock cycle.
    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    // Controller states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/slice_add.sv
// Combinational SLICE-bit ripple adder, time-multiplexed across the slices of a wide operand.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the output follows the inputs.
//
// Ports:
//   a, b : SLICE-bit operands
//   ci   : carry into bit 0
//   s    : SLICE-bit sum
//   co   : carry out of the MSB
//   cm   : carry into the MSB (XOR with co gives signed overflow)
module slice_add #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             cm
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign co = c[SLICE];
    assign cm = c[SLICE-1];

endmodule

// File: rtl/sliced_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor processing SLICE bits per cycle, LSB slice first.
// Latency: WIDTH/SLICE cycles from the start edge to the done pulse; outputs all registered.
// Backpressure: start is only sampled while idle; start during busy is ignored.
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start, sub, ci    : request, subtract select, carry/borrow in (latched on start)
//   a, b, acc         : operands and accumulate select (latched on start)
//   busy, done        : operation in flight, one-cycle completion pulse
//   sum, co, ovf      : result, final carry (1 = no borrow when subtracting), signed overflow
//
// Optional feature: define SLICED_ADDER_ACCUM_EN to let acc=1 substitute the current visible
// sum for a as the first operand. Without it, acc is accepted but has no effect.
module sliced_adder
    import sliced_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    generate
        if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_geometry
            $error("sliced_adder: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    state_t           state_q;
    state_t           state_d;

    // Operand registers shift right by one slice per cycle, so the active slice is always
    // at the bottom and no wide index multiplexer is needed.
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;

    // Partial result: each new slice enters at the top and older slices move down, so after
    // the last slice the register holds the complete result in order.
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] part_d;
    logic [WIDTH+SLICE-1:0] part_cat;

    logic [SLICE-1:0] slice_s;
    logic             slice_co;
    logic             slice_cm;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] first_op;

    assign accept = (state_q == ST_IDLE) && start;
    assign last   = (idx_q == IW'(NS - 1));

`ifdef SLICED_ADDER_ACCUM_EN
    assign first_op = acc ? sum : a;
`else
    assign first_op = a;
    logic unused_acc;
    assign unused_acc = acc;
`endif

    slice_add #(
        .SLICE (SLICE)
    ) u_slice_add (
        .a  (opa_q[SLICE-1:0]),
        .b  (opb_q[SLICE-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co),
        .cm (slice_cm)
    );

    assign part_cat = {slice_s, part_q};
    assign part_d   = part_cat[WIDTH+SLICE-1:SLICE];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            part_q  <= '0;
            sum     <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                opa_q   <= first_op;
                // Subtraction is a + ~b + 1; a caller-supplied ci then acts as borrow-in.
                opb_q   <= sub ? ~b : b;
                carry_q <= ci ^ sub;
                idx_q   <= '0;
            end else if (state_q == ST_RUN) begin
                opa_q   <= opa_q >> SLICE;
                opb_q   <= opb_q >> SLICE;
                carry_q <= slice_co;
                part_q  <= part_d;
                idx_q   <= idx_q + 1'b1;
                if (last) begin
                    sum  <= part_d;
                    co   <= slice_co;
                    ovf  <= slice_cm ^ slice_co;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sliced_adder.sv
module tb_sliced_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        acc;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        co;
    logic        ovf;

    int tests_run;
    int tests_failed;

    sliced_adder dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .acc   (acc),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request at the next falling edge, let it be accepted at the following rising
    // edge, then count cycles until done is seen (bounded). lat counts edges after acceptance.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                          input logic ici, input logic iacc,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        a = ia; b = ib; sub = isub; ci = ici; acc = iacc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 50) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; ci = 1'b0; acc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, sum, co, ovf} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h co=%b ovf=%b, want all 0",
                     busy, done, sum, co, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0, lat, bc);
        tests_run++;
        if (lat !== 4) begin
            tests_failed++; $display("FAIL add_latency: got %0d want 4", lat);
        end
        tests_run++;
        if (bc !== 4) begin
            tests_failed++; $display("FAIL add_busy_cycles: got %0d want 4", bc);
        end
        tests_run++;
        if ({sum, co, ovf} !== {16'h2201, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_result: got sum=%h co=%b ovf=%b want 2201 0 0", sum, co, ovf);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (done !== 1'b0 || sum !== 16'h2201 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_hold: got done=%b busy=%b sum=%h want 0 0 2201", done, busy, sum);
        end
    endtask

    task automatic test_wrap();
        int lat, bc;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, bc);
        tests_run++;
        if (lat !== 4 || {sum, co, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL wrap: got lat=%0d sum=%h co=%b ovf=%b want 4 0000 1 0", lat, sum, co, ovf);
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, bc);
        tests_run++;
        if (lat !== 4 || {sum, co, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL overflow: got lat=%0d sum=%h co=%b ovf=%b want 4 8000 0 1", lat, sum, co, ovf);
        end
    endtask

    task automatic test_subtract();
        int lat, bc;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, lat, bc);
        tests_run++;
        if (lat !== 4 || {sum, co, ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL sub: got lat=%0d sum=%h co=%b ovf=%b want 4 fffe 0 0", lat, sum, co, ovf);
        end
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, lat, bc);
        tests_run++;
        if ({sum, co} !== {16'hFFFD, 1'b0}) begin
            tests_failed++;
            $display("FAIL sub_borrow: got sum=%h co=%b want fffd 0", sum, co);
        end
        run_op(16'h0009, 16'h0003, 1'b1, 1'b0, 1'b0, lat, bc);
        tests_run++;
        if ({sum, co, ovf} !== {16'h0006, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL sub_noborrow: got sum=%h co=%b ovf=%b want 0006 1 0", sum, co, ovf);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; sub = 1'b0; ci = 1'b0; acc = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        // Second request two cycles in, with very different operands.
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; ci = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests_run++;
        if (lat !== 4 || {sum, co, ovf} !== {16'h0003, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL start_ignored: got lat=%0d sum=%h co=%b ovf=%b want 4 0003 0 0", lat, sum, co, ovf);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_ignored_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic d_seen;
        run_op(16'h0100, 16'h0023, 1'b0, 1'b0, 1'b0, lat, bc);
        tests_run++;
        if (sum !== 16'h0123) begin
            tests_failed++; $display("FAIL b2b_first: got sum=%h want 0123", sum);
        end
        // Still inside the done cycle: the next request is accepted at the coming edge.
        d_seen = done;
        run_op(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, lat, bc);
        tests_run++;
        if (d_seen !== 1'b1 || lat !== 4) begin
            tests_failed++;
            $display("FAIL b2b_timing: got done_at_issue=%b lat=%0d want 1 4", d_seen, lat);
        end
        tests_run++;
        if ({sum, co, ovf} !== {16'hFFFF, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_second: got sum=%h co=%b ovf=%b want ffff 0 0", sum, co, ovf);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_cnt;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; ci = 1'b0; acc = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1 || sum !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL rst_pre: got busy=%b sum=%h want 1 ffff", busy, sum);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, sum, co, ovf} !== 20'h0) begin
            tests_failed++;
            $display("FAIL rst_mid: got busy=%b done=%b sum=%h co=%b ovf=%b want all 0",
                     busy, done, sum, co, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done || busy) done_cnt++;
        end
        tests_run++;
        if (done_cnt !== 0 || sum !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_discard: got activity_cycles=%0d sum=%h want 0 0000", done_cnt, sum);
        end
    endtask

    task automatic test_accumulate();
        int lat, bc;
        logic [15:0] exp_sum;
`ifdef SLICED_ADDER_ACCUM_EN
        exp_sum = 16'h0007;
`else
        exp_sum = 16'h0014;
`endif
        run_op(16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, lat, bc);
        tests_run++;
        if (sum !== 16'h0003) begin
            tests_failed++; $display("FAIL accum_seed: got sum=%h want 0003", sum);
        end
        run_op(16'h0010, 16'h0004, 1'b0, 1'b0, 1'b1, lat, bc);
        tests_run++;
        if (lat !== 4 || sum !== exp_sum) begin
            tests_failed++;
            $display("FAIL accum: got lat=%0d sum=%h want 4 %h", lat, sum, exp_sum);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_add();
        test_wrap();
        test_overflow();
        test_subtract();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_accumulate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
